// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with valid tracking, stall/flush, write-back mux and a sticky halt
// once a valid fin instruction retires. Optional retire counter: define MEMWB_RETIRE_CNT_EN.
module memwb_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [1:0]       memtoreg_in,
  input  logic             regwr_in,
  input  logic             fin_in,
  input  logic [4:0]       rd_in,
  input  logic [DW-1:0]    aluout_in,
  input  logic [DW-1:0]    memdata_in,
  input  logic [DW-1:0]    pc4_in,
  output logic             valid_out,
  output logic [1:0]       memtoreg_out,
  output logic             regwr_out,
  output logic             fin_out,
  output logic [4:0]       rd_out,
  output logic [DW-1:0]    wbdata_out,
  output logic             rf_we,
  output logic             halted
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  if (DW < 1) begin : g_bad_dw
    $error("memwb_stage: DW must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("memwb_stage: CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            run_s;
  logic            halted_s;

  logic            valid_q, valid_d;
  logic [1:0]      memtoreg_q, memtoreg_d;
  logic            regwr_q, regwr_d;
  logic            fin_q, fin_d;
  logic [4:0]      rd_q, rd_d;
  logic [DW-1:0]   aluout_q, aluout_d;
  logic [DW-1:0]   memdata_q, memdata_d;
  logic [DW-1:0]   pc4_q, pc4_d;
  logic [DW-1:0]   wbdata_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the fin already in the stage retires on this edge, then the pipe stops
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (valid_q && fin_q) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s    = 1'b0;
    halted_s = 1'b0;
    case (state_q)
      RUN:     run_s    = 1'b1;
      HALT:    halted_s = 1'b1;
      default: run_s    = 1'b0;
    endcase
  end

  // Stage next-state: flush beats stall beats load; everything holds once halted
  always_comb begin
    valid_d    = valid_q;
    memtoreg_d = memtoreg_q;
    regwr_d    = regwr_q;
    fin_d      = fin_q;
    rd_d       = rd_q;
    aluout_d   = aluout_q;
    memdata_d  = memdata_q;
    pc4_d      = pc4_q;
    if (run_s) begin
      if (flush) begin
        valid_d    = 1'b0;
        memtoreg_d = 2'b00;
        regwr_d    = 1'b0;
        fin_d      = 1'b0;
        rd_d       = 5'd0;
      end else if (stall) begin
        valid_d    = valid_q;
      end else begin
        valid_d    = valid_in;
        memtoreg_d = memtoreg_in;
        regwr_d    = regwr_in & valid_in;
        fin_d      = fin_in & valid_in;
        rd_d       = rd_in;
        aluout_d   = aluout_in;
        memdata_d  = memdata_in;
        pc4_d      = pc4_in;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      memtoreg_q <= 2'b00;
      regwr_q    <= 1'b0;
      fin_q      <= 1'b0;
      rd_q       <= 5'd0;
      aluout_q   <= {DW{1'b0}};
      memdata_q  <= {DW{1'b0}};
      pc4_q      <= {DW{1'b0}};
    end else begin
      valid_q    <= valid_d;
      memtoreg_q <= memtoreg_d;
      regwr_q    <= regwr_d;
      fin_q      <= fin_d;
      rd_q       <= rd_d;
      aluout_q   <= aluout_d;
      memdata_q  <= memdata_d;
      pc4_q      <= pc4_d;
    end
  end

  // Write-back source select
  always_comb begin
    wbdata_s = {DW{1'b0}};
    case (memtoreg_q)
      2'b00:   wbdata_s = aluout_q;
      2'b01:   wbdata_s = memdata_q;
      2'b10:   wbdata_s = pc4_q;
      default: wbdata_s = {DW{1'b0}};
    endcase
  end

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Retire counter next-state, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (run_s && valid_q && !stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`endif

  assign valid_out    = valid_q;
  assign memtoreg_out = memtoreg_q;
  assign regwr_out    = regwr_q;
  assign fin_out      = fin_q;
  assign rd_out       = rd_q;
  assign wbdata_out   = wbdata_s;
  assign halted       = halted_s;
  // Register $0 is hard-wired zero, so it is never written
  assign rf_we        = valid_q & regwr_q & (rd_q != 5'd0) & ~halted_s;

endmodule
